// File: rtl/mult_pkg.sv
// Shared types and helpers for the parametrised shift-add multiplier.
// MULT_ZERO_SKIP_EN (optional) selects zero-skipping iteration in the top.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      SIGN
   } state_t;

   // Widest operand that mag() can take. Callers zero-extend into it and cast the result back.
   localparam int MAX_W = 256;

   function automatic int cntW(input int width);
      return $clog2(width + 1);
   endfunction

   function automatic logic [MAX_W-1:0] mag(input logic [MAX_W-1:0] value, input logic isNeg);
      return isNeg ? -value : value;
   endfunction

endpackage

// File: rtl/mult_seq_param_tz_count.sv
// Combinational trailing-zero counter; an all-zero input reports WIDTH.
// Used by mult_seq_param only when MULT_ZERO_SKIP_EN is defined.
module tz_count
   import mult_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic [WIDTH-1:0]        i_q,
   output logic [cntW(WIDTH)-1:0]  o_count
);

   localparam int CNT_W = cntW(WIDTH);

   logic [CNT_W-1:0] w_count;

   // Scanning from the MSB downward leaves the position of the lowest set bit.
   always_comb begin
      w_count = CNT_W'(WIDTH);
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (i_q[i]) begin
            w_count = CNT_W'(i);
         end
      end
   end

   assign o_count = w_count;

endmodule

// File: rtl/mult_seq_param.sv
// Sequential shift-add multiplier, signed or unsigned per operation, ready/start/valid handshake.
// Define MULT_ZERO_SKIP_EN to retire one set multiplier bit per cycle instead of one bit.
module mult_seq_param
   import mult_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 sgn,
   input  logic [WIDTH-1:0]     mlier,
   input  logic [WIDTH-1:0]     mcand,
   output logic                 ready,
   output logic                 valid,
   output logic [2*WIDTH-1:0]   prodt
);

   localparam int CNT_W = cntW(WIDTH);
   localparam int PW    = 2 * WIDTH;

   state_t            r_state;
   state_t            w_stateNext;
   logic [PW-1:0]     r_acc;
   logic [PW-1:0]     r_mcandSh;
   logic [PW-1:0]     r_prodt;
   logic [WIDTH-1:0]  r_q;
   logic              r_neg;
   logic              r_valid;

   logic              w_accept;
   logic              w_done;
   logic              w_zeroStart;
   logic [WIDTH-1:0]  w_magMlier;
   logic [WIDTH-1:0]  w_magMcand;
   logic [PW-1:0]     w_addend;
   logic [PW-1:0]     w_accNext;
   logic [PW-1:0]     w_mcandNext;
   logic [WIDTH-1:0]  w_qNext;

   assign w_magMlier = WIDTH'(mag(MAX_W'(mlier), sgn && mlier[WIDTH-1]));
   assign w_magMcand = WIDTH'(mag(MAX_W'(mcand), sgn && mcand[WIDTH-1]));

`ifdef MULT_ZERO_SKIP_EN
   logic [CNT_W-1:0]  w_tz;
   logic [CNT_W-1:0]  w_step;

   tz_count #(.WIDTH(WIDTH)) u_tzCount (
      .i_q     (r_q),
      .o_count (w_tz)
   );

   // q is never zero in CALC here, so the step is at most WIDTH and fits CNT_W.
   assign w_step      = w_tz + CNT_W'(1);
   assign w_addend    = r_mcandSh << w_tz;
   assign w_mcandNext = r_mcandSh << w_step;
   assign w_qNext     = r_q >> w_step;
   assign w_done      = (w_qNext == '0);
   assign w_zeroStart = (w_magMlier == '0);
`else
   logic [CNT_W-1:0]  r_cnt;

   assign w_addend    = r_q[0] ? r_mcandSh : '0;
   assign w_mcandNext = r_mcandSh << 1;
   assign w_qNext     = r_q >> 1;
   assign w_done      = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_zeroStart = 1'b0;
`endif

   assign w_accNext = r_acc + w_addend;

   // The result strobe cycle keeps ready low so ready and valid are never both high.
   assign ready    = (r_state == IDLE) && !r_valid;
   assign valid    = r_valid;
   assign prodt    = r_prodt;
   assign w_accept = start && ready;

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_stateNext = w_zeroStart ? SIGN : CALC;
            end
         end
         CALC: begin
            if (w_done) begin
               w_stateNext = SIGN;
            end
         end
         SIGN:    w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_acc     <= '0;
         r_mcandSh <= '0;
         r_prodt   <= '0;
         r_q       <= '0;
         r_neg     <= 1'b0;
         r_valid   <= 1'b0;
`ifndef MULT_ZERO_SKIP_EN
         r_cnt     <= '0;
`endif
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_acc     <= '0;
                  r_mcandSh <= PW'(w_magMcand);
                  r_q       <= w_magMlier;
                  r_neg     <= sgn && (mlier[WIDTH-1] ^ mcand[WIDTH-1]);
`ifndef MULT_ZERO_SKIP_EN
                  r_cnt     <= '0;
`endif
               end
            end
            CALC: begin
               r_acc     <= w_accNext;
               r_mcandSh <= w_mcandNext;
               r_q       <= w_qNext;
`ifndef MULT_ZERO_SKIP_EN
               r_cnt     <= r_cnt + CNT_W'(1);
`endif
            end
            SIGN: begin
               // A zero magnitude stays zero even when the operand signs differ.
               r_prodt <= (r_neg && (r_acc != '0)) ? -r_acc : r_acc;
               r_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
